// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Purpose  : Pipelined immediate-extension unit for the CPU decode path.
//            Each accepted instruction word is extended according to its mode
//            (zero / sign / upper / branch / jump). The result is buffered in
//            a small FIFO so that decode and execute can stall independently.
// Ports    : clk, reset_n (async, active-low), flush (sync discard)
//            in_valid/in_ready/ins/mode         - producer handshake
//            out_valid/out_ready/imm_ext/illegal - consumer handshake
//            stat_ops/stat_illegal               - saturating op counters
//                                                  (IMM_EXT_STATS_EN only)
// Config   : define IMM_EXT_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JMP_W  = 26,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ins,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_illegal
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_JUMP   = 3'd4;

  // --------------------------------------------------------------------------
  // Extension datapath (write side)
  // --------------------------------------------------------------------------
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] wr_data;
  logic              wr_illegal;

  // Upper instruction bits are don't-care for some modes; fold them here so
  // they are not reported as dangling.
  logic unused_ins_bits;
  assign unused_ins_bits = ^ins;

  always_comb begin
    imm        = ins[IMM_W-1:0];
    zext       = {{(DATA_W-IMM_W){1'b0}}, imm};
    sext       = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    wr_data    = '0;
    wr_illegal = 1'b0;
    case (mode)
      MODE_ZERO:   wr_data = zext;
      MODE_SIGN:   wr_data = sext;
      MODE_UPPER:  wr_data = zext << IMM_W;
      // The two bits shifted past the MSB are simply lost.
      MODE_BRANCH: wr_data = sext << 2;
      MODE_JUMP:   wr_data = {{(DATA_W-JMP_W){1'b0}}, ins[JMP_W-1:0]} << 2;
      default:     wr_illegal = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          accept;
  logic          wr_en;
  logic          rd_en;

  logic [DATA_W:0] fifo_mem [DEPTH];
  logic [DATA_W:0] head;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  // flush wins over both sides of the handshake in the same cycle.
  assign wr_en     = accept && !flush;
  assign rd_en     = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= {wr_illegal, wr_data};
  end

  assign head    = fifo_mem[rd_ptr_q];
  assign imm_ext = out_valid ? head[DATA_W-1:0] : '0;
  assign illegal = out_valid && head[DATA_W];

  // --------------------------------------------------------------------------
  // Statistics (saturating, cleared by reset only; flushed writes still count)
  // --------------------------------------------------------------------------
`ifdef IMM_EXT_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_illegal_q, stat_illegal_d;

  always_comb begin
    stat_ops_d     = stat_ops_q;
    stat_illegal_d = stat_illegal_q;
    if (accept && !(&stat_ops_q)) stat_ops_d = stat_ops_q + 1'b1;
    if (accept && wr_illegal && !(&stat_illegal_q)) stat_illegal_d = stat_illegal_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q     <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_ops_q     <= stat_ops_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule
`default_nettype wire
